// File: rtl/aes_masked_pkg.sv
// aes_masked_pkg: shared constants and FSM encoding for the masked SubBytes sequencer.
package aes_masked_pkg;
   localparam int NUM_BYTES    = 16;
   localparam int SBOX_LAT_DEF = 5;
   localparam int IDX_W        = 4;
   typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN, ST_DONE} state_t;
endpackage

// File: rtl/valid_tag_sr.sv
// valid_tag_sr: 1-bit delay line marking which S-box output cycles carry a real byte.
module valid_tag_sr #(
   parameter int DEPTH = 5
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);
   logic [DEPTH-1:0] r_sr;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_sr <= '0;
      else          r_sr <= (r_sr << 1) | DEPTH'(i_d);
   assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/masked_subbytes_seq.sv
// masked_subbytes_seq: streams a shared 16-byte state through an external pipelined
// masked S-box one byte per cycle and reassembles the substituted shares.
module masked_subbytes_seq
   import aes_masked_pkg::*;
#(
   parameter int SHARES   = 2,
   parameter int SBOX_LAT = SBOX_LAT_DEF
) (
   input  logic                  ClkxCI,
   input  logic                  RstxBI,
   input  logic                  StartxSI,
   input  logic [128*SHARES-1:0] StatexDI,
   output logic [8*SHARES-1:0]   SboxInxDO,
   input  logic [8*SHARES-1:0]   SboxOutxDI,
   output logic                  BusyxSO,
   output logic                  DonexSO,
   output logic [128*SHARES-1:0] StatexDO
);
   state_t                r_st, w_st_nxt;
   logic [IDX_W-1:0]      r_feed_cnt, r_cap_cnt;
   logic [128*SHARES-1:0] r_state;
   logic                  w_start, w_feed, w_tag, w_feed_last, w_cap_last;

   assign w_start     = StartxSI && (r_st == ST_IDLE || r_st == ST_DONE);
   assign w_feed      = r_st == ST_FEED;
   assign w_feed_last = r_feed_cnt == IDX_W'(NUM_BYTES-1);
   assign w_cap_last  = w_tag && r_cap_cnt == IDX_W'(NUM_BYTES-1);

   valid_tag_sr #(.DEPTH(SBOX_LAT)) u_tag (
      .i_clk  (ClkxCI),
      .i_rst_n(RstxBI),
      .i_d    (w_feed),
      .o_q    (w_tag)
   );

   always_comb begin
      w_st_nxt = r_st;
      BusyxSO  = 1'b0;
      DonexSO  = 1'b0;
      case (r_st)
         ST_IDLE:  w_st_nxt = w_start ? ST_FEED : ST_IDLE;
         ST_FEED: begin
            BusyxSO  = 1'b1;
            w_st_nxt = w_feed_last ? ST_DRAIN : ST_FEED;
         end
         ST_DRAIN: begin
            BusyxSO  = 1'b1;
            w_st_nxt = w_cap_last ? ST_DONE : ST_DRAIN;
         end
         default: begin
            DonexSO  = 1'b1;
            w_st_nxt = w_start ? ST_FEED : ST_IDLE;
         end
      endcase
   end

   // Each share is sliced independently; shares never meet inside this block.
   always_comb begin
      SboxInxDO = '0;
      for (int s = 0; s < SHARES; s++)
         SboxInxDO[s*8 +: 8] = w_feed ? r_state[s*128 + 8*r_feed_cnt +: 8] : 8'h00;
   end

   always_ff @(posedge ClkxCI or negedge RstxBI)
      if (!RstxBI) begin
         r_st       <= ST_IDLE;
         r_feed_cnt <= '0;
         r_cap_cnt  <= '0;
         r_state    <= '0;
         StatexDO   <= '0;
      end else begin
         r_st <= w_st_nxt;
         if (w_start) begin
            r_state    <= StatexDI;
            r_feed_cnt <= '0;
            r_cap_cnt  <= '0;
         end else begin
            if (w_feed) r_feed_cnt <= r_feed_cnt + 1'b1;
            if (w_tag)  r_cap_cnt  <= r_cap_cnt + 1'b1;
         end
         if (w_tag)
            for (int s = 0; s < SHARES; s++)
               StatexDO[s*128 + 8*r_cap_cnt +: 8] <= SboxOutxDI[s*8 +: 8];
      end
endmodule

// File: tb/tb_masked_subbytes_seq.sv
// tb_masked_subbytes_seq: runs SBOX_LAT=5 and SBOX_LAT=8 instances against a
// behavioural masked S-box and an unmasked AES SubBytes reference.
module tb_masked_subbytes_seq;
   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         st [2];
   logic [255:0] sdi [2];
   logic [255:0] sdo [2];
   logic [15:0]  sin [2];
   logic [15:0]  sout [2];
   logic         busy [2];
   logic         done [2];
   logic         exp_feed [2];
   logic         mon_en = 1'b0;
   int           total = 0;
   int           bad = 0;
   logic [7:0]   sbox_t [256];
   logic [15:0]  pipe [2][8];

   always #5 clk = ~clk;

   masked_subbytes_seq #(.SHARES(2), .SBOX_LAT(5)) u_dut5 (
      .ClkxCI(clk), .RstxBI(rst_n), .StartxSI(st[0]), .StatexDI(sdi[0]),
      .SboxInxDO(sin[0]), .SboxOutxDI(sout[0]), .BusyxSO(busy[0]),
      .DonexSO(done[0]), .StatexDO(sdo[0])
   );

   masked_subbytes_seq #(.SHARES(2), .SBOX_LAT(8)) u_dut8 (
      .ClkxCI(clk), .RstxBI(rst_n), .StartxSI(st[1]), .StatexDI(sdi[1]),
      .SboxInxDO(sin[1]), .SboxOutxDI(sout[1]), .BusyxSO(busy[1]),
      .DonexSO(done[1]), .StatexDO(sdo[1])
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] v = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
         sbox_t[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
      end
   endtask

   // Masked S-box model: fresh output mask every cycle, recombines to the plain S-box.
   function automatic logic [15:0] msbox(input logic [15:0] x, input logic [7:0] m);
      return {m, sbox_t[x[7:0] ^ x[15:8]] ^ m};
   endfunction

   always @(posedge clk)
      for (int d = 0; d < 2; d++) begin
         for (int k = 7; k > 0; k--) pipe[d][k] <= pipe[d][k-1];
         pipe[d][0] <= msbox(sin[d], 8'($urandom));
      end

   assign sout[0] = pipe[0][4];
   assign sout[1] = pipe[1][7];

   always @(negedge clk)
      if (mon_en)
         for (int d = 0; d < 2; d++)
            if (!exp_feed[d]) begin
               total++;
               if (sin[d] !== 16'h0) begin
                  bad++;
                  $display("FAIL sbox_in_outside_feed dut%0d: got %h want 0000", d, sin[d]);
               end
            end

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [255:0] split(input logic [127:0] p);
      logic [127:0] m = rnd128();
      return {m, p ^ m};
   endfunction

   function automatic logic [127:0] rec(input logic [255:0] x);
      return x[127:0] ^ x[255:128];
   endfunction

   function automatic logic [127:0] exp_sub(input logic [127:0] p);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_t[p[8*i +: 8]];
      return r;
   endfunction

   // Drives one start sequence and records done timing/results; edge n counts from the start edge.
   task automatic run(input int d, input logic [255:0] a, input logic [255:0] b,
                      input int hold, input int ncyc,
                      output int d1, output int d2, output int nd,
                      output logic [255:0] r1, output logic [255:0] r2, output logic [255:0] fin);
      int lat = d ? 8 : 5;
      int s = -1000;
      d1 = -1; d2 = -1; nd = 0; r1 = '0; r2 = '0;
      @(negedge clk);
      sdi[d] = a;
      st[d] = 1'b1;
      for (int n = 0; n < ncyc; n++) begin
         @(posedge clk);
         if (st[d] && n >= s + 17 + lat) s = n;
         #1 exp_feed[d] = (n - s) <= 15;
         @(negedge clk);
         if (done[d]) begin
            nd++;
            if (d1 < 0) begin d1 = n; r1 = sdo[d]; end
            else if (d2 < 0) begin d2 = n; r2 = sdo[d]; end
         end
         if (n == 2) sdi[d] = b;
         if (n + 1 >= hold) st[d] = 1'b0;
      end
      fin = sdo[d];
      exp_feed[d] = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         total += 4;
         if (busy[d] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d: got %b want 0", d, busy[d]); end
         if (done[d] !== 1'b0) begin bad++; $display("FAIL reset_done dut%0d: got %b want 0", d, done[d]); end
         if (sin[d] !== 16'h0) begin bad++; $display("FAIL reset_sbox_in dut%0d: got %h want 0", d, sin[d]); end
         if (sdo[d] !== 256'h0) begin bad++; $display("FAIL reset_state_out dut%0d: got %h want 0", d, sdo[d]); end
      end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic check_single(input string nm, input int d, input logic [127:0] p, input logic [255:0] a);
      int d1, d2, nd, lat;
      logic [255:0] r1, r2, fin;
      lat = d ? 8 : 5;
      run(d, a, split(rnd128()), 1, 22 + lat, d1, d2, nd, r1, r2, fin);
      total += 4;
      if (d1 != 16 + lat) begin bad++; $display("FAIL %s_done_cycle dut%0d: got %0d want %0d", nm, d, d1, 16 + lat); end
      if (nd != 1) begin bad++; $display("FAIL %s_done_pulses dut%0d: got %0d want 1", nm, d, nd); end
      if (rec(r1) !== exp_sub(p)) begin bad++; $display("FAIL %s_result dut%0d: got %h want %h", nm, d, rec(r1), exp_sub(p)); end
      if (fin !== r1) begin bad++; $display("FAIL %s_hold dut%0d: got %h want %h", nm, d, fin, r1); end
   endtask

   task automatic test_zero(input int d);
      check_single("zero", d, 128'h0, 256'h0);
      total++;
      if (rec(sdo[d]) !== {16{8'h63}}) begin bad++; $display("FAIL zero_63 dut%0d: got %h want all 63", d, rec(sdo[d])); end
   endtask

   task automatic test_fips(input int d);
      logic [127:0] p;
      for (int i = 0; i < 16; i++) p[8*i +: 8] = 8'(i * 17);
      check_single("fips", d, p, split(p));
   endtask

   task automatic test_random(input int d);
      for (int k = 0; k < 3; k++) begin
         logic [127:0] p = rnd128();
         check_single("random", d, p, split(p));
      end
   endtask

   task automatic test_back_to_back(input int d);
      int d1, d2, nd, lat;
      logic [255:0] a, b, r1, r2, fin;
      lat = d ? 8 : 5;
      a = split(rnd128());
      b = split(rnd128());
      run(d, a, b, 18 + lat, 2 * (17 + lat) + 4, d1, d2, nd, r1, r2, fin);
      total += 5;
      if (d1 != 16 + lat) begin bad++; $display("FAIL b2b_done1 dut%0d: got %0d want %0d", d, d1, 16 + lat); end
      if (d2 != 33 + 2 * lat) begin bad++; $display("FAIL b2b_done2 dut%0d: got %0d want %0d", d, d2, 33 + 2 * lat); end
      if (nd != 2) begin bad++; $display("FAIL b2b_pulses dut%0d: got %0d want 2", d, nd); end
      if (rec(r1) !== exp_sub(rec(a))) begin bad++; $display("FAIL b2b_result1 dut%0d: got %h want %h", d, rec(r1), exp_sub(rec(a))); end
      if (rec(r2) !== exp_sub(rec(b))) begin bad++; $display("FAIL b2b_result2 dut%0d: got %h want %h", d, rec(r2), exp_sub(rec(b))); end
   endtask

   task automatic test_reset_midrun();
      logic [127:0] p;
      mon_en = 1'b0;
      @(negedge clk);
      sdi[0] = split(rnd128());
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total += 4;
      if (busy[0] !== 1'b0) begin bad++; $display("FAIL midrun_busy: got %b want 0", busy[0]); end
      if (done[0] !== 1'b0) begin bad++; $display("FAIL midrun_done: got %b want 0", done[0]); end
      if (sin[0] !== 16'h0) begin bad++; $display("FAIL midrun_sbox_in: got %h want 0", sin[0]); end
      if (sdo[0] !== 256'h0) begin bad++; $display("FAIL midrun_state_out: got %h want 0", sdo[0]); end
      @(posedge clk);
      #2 rst_n = 1'b1;
      mon_en = 1'b1;
      p = rnd128();
      check_single("after_reset", 0, p, split(p));
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         st[d] = 1'b0;
         sdi[d] = '0;
         exp_feed[d] = 1'b0;
      end
      build_sbox();
      test_reset();
      for (int d = 0; d < 2; d++) begin
         test_zero(d);
         test_fips(d);
         test_random(d);
         test_back_to_back(d);
      end
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
